// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : Write buffer in front of the byte-addressable data memory.
//            Stores are queued in a DEPTH-entry FIFO and committed to memory
//            whenever the single memory port is not used by a load. Loads
//            have priority on the port. A load that overlaps a queued store
//            (word granularity, both first and last byte of the access)
//            stalls while the head drains, so memory ordering is preserved.
//
// Optional : STORE_FWD_EN - when defined, a conflicting load whose youngest
//            overlapping store has the same address and size gets its data
//            forwarded from the buffer (no stall, head still drains).
//
// Ports    : clk, reset           - clock, synchronous active-high reset
//            req_valid/req_write  - MEM-stage request present / is store
//            req_addr/req_wdata   - byte address / store data
//            req_funct3           - RV32I load/store funct3
//            stall                - request not consumed this cycle
//            ld_data              - load result (0 unless unstalled load)
//            empty                - no queued stores
//            mem_*                - data memory port (read data is comb.)
//
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              empty,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_read_data
);

    localparam int               C_PTR_W = $clog2(DEPTH);
    localparam logic [C_PTR_W:0] C_FULL  = DEPTH[C_PTR_W:0];

    // Entry storage
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [31:0]        data_q [DEPTH];
    logic [2:0]         f3_q   [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [C_PTR_W-1:0] head_q, head_d;
    logic [C_PTR_W-1:0] tail_q, tail_d;
    logic [C_PTR_W:0]   count_q, count_d;

    logic               w_load;
    logic               w_store;
    logic               w_full;
    logic               w_enq;
    logic               w_port_ld;
    logic               w_drain;
    logic [ADDR_W-1:0]  w_last_addr;
    logic               w_conflict;
    logic [C_PTR_W-1:0] w_idx;
    logic               w_fwd_hit;
    logic [31:0]        w_fwd_data;
`ifdef STORE_FWD_EN
    logic [C_PTR_W-1:0] w_young;
    logic [31:0]        w_young_data;
`endif

    assign w_load    = req_valid & ~req_write;
    assign w_store   = req_valid & req_write &
                       ((req_funct3 == 3'b000) | (req_funct3 == 3'b001) | (req_funct3 == 3'b010));
    assign w_full    = (count_q == C_FULL);
    // Reset gates every port action so queued stores are discarded unwritten.
    assign w_enq     = ~reset & w_store & ~w_full;
    assign w_port_ld = ~reset & w_load & ~w_conflict;
    assign w_drain   = ~reset & ~w_port_ld & (count_q != '0);
    assign empty     = (count_q == '0);

    // Address of the last byte touched by the load (wraps mod 2^ADDR_W).
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   w_last_addr = req_addr;
            2'b01:   w_last_addr = req_addr + ADDR_W'(1);
            default: w_last_addr = req_addr + ADDR_W'(3);
        endcase
    end

    // Scan oldest to youngest; the last match is the youngest overlap.
    always_comb begin
        w_conflict = 1'b0;
        w_idx      = head_q;
`ifdef STORE_FWD_EN
        w_young    = head_q;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = head_q + C_PTR_W'(k);
            if (valid_q[w_idx] &&
                ((addr_q[w_idx][ADDR_W-1:2] == req_addr[ADDR_W-1:2]) ||
                 (addr_q[w_idx][ADDR_W-1:2] == w_last_addr[ADDR_W-1:2]))) begin
                w_conflict = 1'b1;
`ifdef STORE_FWD_EN
                w_young    = w_idx;
`endif
            end
        end
    end

`ifdef STORE_FWD_EN
    always_comb begin
        w_young_data = data_q[w_young];
        w_fwd_hit    = w_conflict && (addr_q[w_young] == req_addr) &&
                       (f3_q[w_young][1:0] == req_funct3[1:0]);
        case (req_funct3)
            3'b000:  w_fwd_data = {{24{w_young_data[7]}}, w_young_data[7:0]};
            3'b001:  w_fwd_data = {{16{w_young_data[15]}}, w_young_data[15:0]};
            3'b100:  w_fwd_data = {24'd0, w_young_data[7:0]};
            3'b101:  w_fwd_data = {16'd0, w_young_data[15:0]};
            default: w_fwd_data = w_young_data;
        endcase
    end
`else
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = '0;
`endif

    // Outputs and memory port
    always_comb begin
        stall          = 1'b0;
        ld_data        = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_funct3     = '0;
        if (!reset) begin
            stall = (w_store & w_full) | (w_load & w_conflict & ~w_fwd_hit);
            if (w_port_ld) begin
                mem_read    = 1'b1;
                mem_address = req_addr;
                mem_funct3  = req_funct3;
                ld_data     = mem_read_data;
            end else if (w_drain) begin
                mem_write      = 1'b1;
                mem_address    = addr_q[head_q];
                mem_write_data = data_q[head_q];
                mem_funct3     = f3_q[head_q];
            end
            if (w_load && w_conflict && w_fwd_hit) begin
                ld_data = w_fwd_data;
            end
        end
    end

    // Next-state pointers and occupancy
    always_comb begin
        head_d  = w_drain ? head_q + 1'b1 : head_q;
        tail_d  = w_enq   ? tail_q + 1'b1 : tail_q;
        count_d = count_q + (C_PTR_W + 1)'(w_enq) - (C_PTR_W + 1)'(w_drain);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                f3_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (w_drain) begin
                valid_q[head_q] <= 1'b0;
            end
            if (w_enq) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= req_addr;
                data_q[tail_q]  <= req_wdata;
                f3_q[tail_q]    <= req_funct3;
            end
        end
    end

endmodule
`default_nettype wire
